// File: rtl/sfp_acc_if.sv
// rtl/sfp_acc_if.sv - accumulate/readout bus between the pmem read port and sfp_acc
interface sfp_acc_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_kij = 9
);
    localparam int cnt_bw = $clog2(len_kij + 1);

    logic                     acc;
    logic                     clr;
    logic [col*psum_bw-1:0]   psum_in;
    logic [col*psum_bw-1:0]   sfp_out;
    logic                     valid;
    logic [cnt_bw-1:0]        acc_cnt;
    logic                     sat_flag;

    modport master (
        output acc, clr, psum_in,
        input  sfp_out, valid, acc_cnt, sat_flag
    );

    modport slave (
        input  acc, clr, psum_in,
        output sfp_out, valid, acc_cnt, sat_flag
    );
endinterface

// File: rtl/sfp_acc.sv
// rtl/sfp_acc.sv - saturating kij accumulator with registered output (optional ReLU via SFP_RELU_EN)
module sfp_acc #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_kij = 9
) (
    input  logic        clk,
    input  logic        reset,
    sfp_acc_if.slave    bus
);
    localparam int cnt_bw = $clog2(len_kij + 1);
    localparam logic [cnt_bw-1:0]  cnt_last = cnt_bw'(len_kij);
    localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                  state, state_nxt;
    logic [cnt_bw-1:0]       cnt, cnt_nxt;
    logic [col*psum_bw-1:0]  acc_q, acc_nxt;
    logic [col*psum_bw-1:0]  sat_sum;
    logic [col-1:0]          lane_sat;
    logic [col*psum_bw-1:0]  out_q, out_nxt;
    logic                    sat_q, sat_nxt;
    logic                    done_hit, done_nxt;
    logic                    valid_q;

    // Per-lane add in psum_bw+1 bits, clamped back to the lane range
    always_comb begin
        logic [psum_bw-1:0] a;
        logic [psum_bw-1:0] p;
        logic [psum_bw:0]   wide;
        sat_sum  = '0;
        lane_sat = '0;
        for (int c = 0; c < col; c++) begin
            a    = acc_q[c*psum_bw +: psum_bw];
            p    = bus.psum_in[c*psum_bw +: psum_bw];
            wide = {a[psum_bw-1], a} + {p[psum_bw-1], p};
            if (wide[psum_bw] != wide[psum_bw-1]) begin
                sat_sum[c*psum_bw +: psum_bw] = wide[psum_bw] ? lane_min : lane_max;
                lane_sat[c] = 1'b1;
            end else begin
                sat_sum[c*psum_bw +: psum_bw] = wide[psum_bw-1:0];
            end
        end
    end

    // Next-state: clr dominates, strobes count up to len_kij, DONE ignores further strobes
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc_q;
        sat_nxt   = sat_q;
        done_nxt  = 1'b0;
        if (bus.clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (bus.acc) begin
                        acc_nxt = sat_sum;
                        sat_nxt = sat_q | (|lane_sat);
                        cnt_nxt = cnt + cnt_bw'(1);
                        if (cnt_nxt == cnt_last) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ACC;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output function: rectify negative lanes when ReLU is built in, else pass through
    always_comb begin
        out_nxt = acc_q;
`ifdef SFP_RELU_EN
        for (int c = 0; c < col; c++) begin
            if (acc_q[c*psum_bw + psum_bw - 1]) begin
                out_nxt[c*psum_bw +: psum_bw] = '0;
            end
        end
`endif
    end

    // State, accumulators and flags; reset aborts any partial sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            done_hit <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc_q    <= acc_nxt;
            sat_q    <= sat_nxt;
            done_hit <= done_nxt;
        end
    end

    // Output stage lags the accumulator by one cycle; valid lines up with the final word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_nxt;
            valid_q <= done_hit;
        end
    end

    assign bus.sfp_out  = out_q;
    assign bus.valid    = valid_q;
    assign bus.acc_cnt  = cnt;
    assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_sfp_acc.sv
// tb/tb_sfp_acc.sv - scoreboard bench for sfp_acc
module tb_sfp_acc;
    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int LEN = 9;
    localparam int W   = COL*PBW;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   cnt;
        logic         sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   vcount = 0;
    exp_t sb[$];

    sfp_acc_if #(.col(COL), .psum_bw(PBW), .len_kij(LEN)) bus ();

    sfp_acc #(.col(COL), .psum_bw(PBW), .len_kij(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lanes(input logic [PBW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = v;
        return r;
    endfunction

    // Monitor: every valid cycle pops one expected result
    always @(negedge clk) begin
        if (!reset && bus.valid === 1'b1) begin
            vcount++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid with sfp_out %h expected no result", bus.sfp_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sfp_out", bus.sfp_out, e.data);
                check("sb_acc_cnt", W'(bus.acc_cnt), W'(e.cnt));
                check("sb_sat_flag", W'(bus.sat_flag), W'(e.sat));
            end
        end
    end

    task automatic do_acc(input logic [W-1:0] p);
        bus.acc = 1'b1;
        bus.psum_in = p;
        @(posedge clk);
        #1;
        bus.acc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d, input logic [3:0] c, input logic s);
        exp_t e;
        e.data = d;
        e.cnt = c;
        e.sat = s;
        sb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] e;
        int v0;

        reset = 1'b1;
        bus.acc = 1'b0;
        bus.clr = 1'b0;
        bus.psum_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_sfp_out", bus.sfp_out, '0);
        check("rst_valid", W'(bus.valid), '0);
        check("rst_acc_cnt", W'(bus.acc_cnt), '0);
        check("rst_sat_flag", W'(bus.sat_flag), '0);

        // 9 back-to-back strobes of 3
        v0 = vcount;
        push(lanes(16'd27), 4'd9, 1'b0);
        for (int i = 0; i < LEN; i++) do_acc(lanes(16'd3));
        check("b2b_acc_cnt", W'(bus.acc_cnt), W'(9));
        idle(3);
        check("b2b_valid_pulses", W'(vcount - v0), W'(1));
        check("b2b_hold", bus.sfp_out, lanes(16'd27));
        do_clr();
        check("clr_acc_cnt", W'(bus.acc_cnt), '0);
        idle(1);
        check("clr_sfp_out", bus.sfp_out, '0);

        // Negative lane 0, ReLU dependent
        p = lanes(16'd1);
        p[15:0] = 16'hFFFB;
        e = lanes(16'd9);
`ifdef SFP_RELU_EN
        e[15:0] = 16'h0000;
`else
        e[15:0] = 16'hFFD3;
`endif
        push(e, 4'd9, 1'b0);
        for (int i = 0; i < LEN; i++) do_acc(p);
        idle(3);
        do_clr();

        // 4 strobes, gap, 5 strobes, then a strobe in DONE
        for (int i = 0; i < 4; i++) do_acc(lanes(16'd2));
        for (int i = 0; i < 3; i++) begin
            check("gap_acc_cnt", W'(bus.acc_cnt), W'(4));
            idle(1);
        end
        v0 = vcount;
        push(lanes(16'd18), 4'd9, 1'b0);
        for (int i = 0; i < 5; i++) do_acc(lanes(16'd2));
        idle(3);
        do_acc(lanes(16'd2));
        idle(3);
        check("done_valid_pulses", W'(vcount - v0), W'(1));
        check("done_acc_cnt", W'(bus.acc_cnt), W'(9));
        check("done_sfp_out", bus.sfp_out, lanes(16'd18));
        do_clr();

        // Saturation on lane 3
        p = '0;
        p[63:48] = 16'h7000;
        do_acc(p);
        do_acc(p);
        idle(1);
        e = '0;
        e[63:48] = 16'h7FFF;
        check("sat_lane3", bus.sfp_out, e);
        check("sat_flag_set", W'(bus.sat_flag), W'(1));
        check("sat_acc_cnt", W'(bus.acc_cnt), W'(2));
        push(e, 4'd9, 1'b1);
        for (int i = 0; i < 7; i++) do_acc('0);
        idle(3);
        do_clr();
        idle(1);
        check("sat_clr_out", bus.sfp_out, '0);
        check("sat_clr_flag", W'(bus.sat_flag), '0);
        check("sat_clr_cnt", W'(bus.acc_cnt), '0);

        // clr and acc together after 5 adds
        for (int i = 0; i < 5; i++) do_acc(lanes(16'd1));
        bus.clr = 1'b1;
        bus.acc = 1'b1;
        bus.psum_in = lanes(16'd5);
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        bus.acc = 1'b0;
        check("clracc_cnt", W'(bus.acc_cnt), '0);
        idle(1);
        check("clracc_out", bus.sfp_out, '0);
        push(lanes(16'd9), 4'd9, 1'b0);
        for (int i = 0; i < LEN; i++) do_acc(lanes(16'd1));
        idle(3);
        do_clr();

        // Asynchronous reset mid-accumulation
        for (int i = 0; i < 6; i++) do_acc(lanes(16'd4));
        check("pre_rst_cnt", W'(bus.acc_cnt), W'(6));
        #2;
        reset = 1'b1;
        #1;
        check("arst_sfp_out", bus.sfp_out, '0);
        check("arst_acc_cnt", W'(bus.acc_cnt), '0);
        check("arst_valid", W'(bus.valid), '0);
        #3;
        reset = 1'b0;
        idle(1);
        push(lanes(16'd45), 4'd9, 1'b0);
        for (int i = 0; i < LEN; i++) do_acc(lanes(16'd5));
        idle(3);

        check("sb_empty", W'(sb.size()), '0);
        check("total_valids", W'(vcount), W'(6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sfp_acc.md
# sfp_acc

Special-function/accumulation stage that consumes partial sums read back from psum memory under the `acc` instruction bit and produces the final output-feature-map word on `sfp_out`. It is the responder side of the accumulation protocol: each `acc` strobe adds one kij partial-sum vector per column until `len_kij` contributions have been summed. The result is optionally rectified and held for readout. It sits between the pmem read port and the core's `sfp_out` output.

## Interface
- `col`, default 8: number of output channels (columns).
- `psum_bw`, default 16: signed width of each psum lane and accumulator.
- `len_kij`, default 9: contributions per output pixel.
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `acc`  in  1  accumulate strobe, qualified with `psum_in` on the same edge.
- `clr`  in  1  synchronous clear before the next output pixel.
- `psum_in`  in  `col*psum_bw`  pmem Q data; lane c is bits `[psum_bw*(c+1)-1 : psum_bw*c]`, two's complement.
- `sfp_out`  out  `col*psum_bw`  registered result, same lane packing.
- `valid`  out  1  one-cycle pulse when `sfp_out` first holds the complete sum.
- `acc_cnt`  out  `$clog2(len_kij+1)`  contributions summed so far.
- `sat_flag`  out  1  sticky flag; set when any lane saturated since the last clear.

## Operation
- States: IDLE (cnt=0), ACC (0<cnt<len_kij), DONE (cnt=len_kij).
- `acc`=1 in IDLE or ACC:
  - Each lane updates `a_c <= sat(a_c + psum_in_c)`.
  - `cnt++`.
  - Transition to ACC, or to DONE when the new cnt equals `len_kij`.
- `acc`=0 in ACC: hold `a_c` and cnt. Gaps between strobes are legal.
- `acc`=1 in DONE: ignored. Accumulators, cnt and flags are unchanged.
- Arithmetic:
  - The sum is formed in `psum_bw+1` bits.
  - It is clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Any clamp sets `sat_flag`.
- `clr`=1 zeroes `a_c`, cnt and `sat_flag`, and returns to IDLE. `clr` wins over a simultaneous `acc`; that psum is dropped.
- Output register: `sfp_out_c <= f(a_c)` every cycle. `f` is defined under Configuration.
- `valid` is registered. It is asserted in the cycle after the add that enters DONE, and is low otherwise.

## Timing
- Reset values: `sfp_out`=0, `valid`=0, `acc_cnt`=0, `sat_flag`=0, state IDLE, all `a_c`=0.
- `psum_in` is sampled at edge N when `acc`=1. The accumulator updates at edge N. `sfp_out` reflects the update at edge N+1, which gives one cycle of latency from accumulator to output.
- Final add at edge N: `valid`=1 during cycle N+1 to N+2, with `sfp_out` already final. `sfp_out` then holds until `clr` or `reset`.
- `reset` asserted mid-accumulation aborts immediately and asynchronously. No partial result is retained.
- `clr` at edge M: `sfp_out` reads 0 from edge M+1.
- Back-to-back strobes: `len_kij` consecutive `acc` cycles complete in `len_kij` cycles. There is no throughput penalty.

## Configuration
- `SFP_RELU_EN` defined: `f(x) = (x<0) ? 0 : x` per lane. The accumulator keeps its signed value, and `sat_flag` is unaffected by rectification.
- `SFP_RELU_EN` undefined: `f(x) = x`, so `sfp_out` carries the raw signed sum.

## Test plan
- Reset, then 9 back-to-back `acc` with every lane = 16'd3 → `sfp_out` lanes = 27 at the cycle after the 9th edge, `valid` high for exactly 1 cycle, `acc_cnt`=9.
- 9 strobes with lane0 = 16'sd-5, other lanes +1, RELU on → lane0=0, others=9. Same stimulus with RELU off → lane0=16'hFFD3 (-45).
- 4 strobes, 3 idle cycles, 5 more strobes (value 2) → `acc_cnt` holds 4 during the gap, final lanes=18, a single `valid` pulse. A 10th strobe in DONE changes nothing and `valid` stays low.
- Lane3 = 16'h7000 for 2 strobes → lane3=16'h7FFF, `sat_flag`=1. `clr` → all zero, `sat_flag`=0, IDLE.
- `clr` and `acc` in the same cycle after 5 adds → `acc_cnt`=0, sums 0, the psum is discarded.
- `reset` pulsed asynchronously mid-accumulation (between edges, cnt=6) → all outputs 0 immediately. 9 fresh strobes then produce a correct result.
